// File: rtl/fifo_uart_tx_if.sv
// FIFO-to-UART transmitter bus bundle.
//   enable    : transmit permission (driven by master)
//   empty     : upstream FIFO empty flag (driven by master)
//   fifo_data : upstream FIFO head byte (driven by master)
//   remove    : one-cycle pop strobe back to the FIFO (driven by slave)
//   tx        : serial line, idle high (driven by slave)
//   busy      : frame in progress (driven by slave)
interface fifo_uart_tx_if;
   logic       enable;
   logic       empty;
   logic [7:0] fifo_data;
   logic       remove;
   logic       tx;
   logic       busy;

   modport master (
      output enable, empty, fifo_data,
      input  remove, tx, busy
   );

   modport slave (
      input  enable, empty, fifo_data,
      output remove, tx, busy
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from an upstream FIFO and sends them as 8N1 UART frames.
//   ck    : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : slave side of fifo_uart_tx_if (enable/empty/fifo_data in,
//           remove/tx/busy out); tx and busy are registered, remove is
//           combinational from state and FIFO flags.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic           ck,
   input  logic           reset,
   fifo_uart_tx_if.slave  bus
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             tx_q, tx_nxt;
   logic             busy_q, busy_nxt;
   logic             bit_done;
   logic             fetch;

   assign bit_done = (cnt == CNT_LAST);
   // Reset gating keeps the pop strobe quiet while reset holds state at IDLE.
   assign fetch    = (state == IDLE) && bus.enable && !bus.empty && !reset;

   assign bus.remove = fetch;
   assign bus.tx     = tx_q;
   assign bus.busy   = busy_q;

   // State and datapath registers
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         shift  <= '0;
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         idx    <= idx_nxt;
         shift  <= shift_nxt;
         tx_q   <= tx_nxt;
         busy_q <= busy_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fetch) state_nxt = START;
         START:   if (bit_done) state_nxt = DATA;
         DATA:    if (bit_done && (idx == 3'd7)) state_nxt = STOP;
         STOP:    if (bit_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shift_nxt = shift;
      tx_nxt    = tx_q;
      busy_nxt  = busy_q;
      case (state)
         IDLE: begin
            cnt_nxt  = '0;
            idx_nxt  = '0;
            tx_nxt   = 1'b1;
            busy_nxt = 1'b0;
            if (fetch) begin
               shift_nxt = bus.fifo_data;
               tx_nxt    = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         START: begin
            if (bit_done) begin
               cnt_nxt = '0;
               idx_nxt = '0;
               tx_nxt  = shift[0];
            end else begin
               cnt_nxt = CNT_W'(cnt + 1'b1);
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_nxt = '0;
               if (idx == 3'd7) begin
                  tx_nxt = 1'b1;
               end else begin
                  idx_nxt = 3'(idx + 3'd1);
                  tx_nxt  = shift[3'(idx + 3'd1)];
               end
            end else begin
               cnt_nxt = CNT_W'(cnt + 1'b1);
            end
         end
         STOP: begin
            if (bit_done) begin
               cnt_nxt  = '0;
               busy_nxt = 1'b0;
            end else begin
               cnt_nxt = CNT_W'(cnt + 1'b1);
            end
         end
         default: begin
            cnt_nxt  = '0;
            tx_nxt   = 1'b1;
            busy_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..65535.
REQ-002 ck  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  transmit permission; sampled only in IDLE.
REQ-005 empty  input  1  FIFO empty flag from the upstream FIFO.
REQ-006 fifo_data  input  8  FIFO head byte; valid whenever empty=0.
REQ-007 remove  output  1  one-cycle pop strobe to the FIFO.
REQ-008 tx  output  1  serial line; idle high; registered.
REQ-009 busy  output  1  high from frame start until return to IDLE; registered.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA and STOP, plus a bit-cycle counter and a 3-bit bit index.
REQ-011 remove SHALL be combinational: remove = (state==IDLE) && enable && !empty; no other condition asserts it.
REQ-012 On the edge where remove=1, the block SHALL latch fifo_data into an 8-bit shift register, set tx<=0, set busy<=1, clear the counter and go to START.
REQ-013 START SHALL hold tx=0 for exactly CLKS_PER_BIT cycles, then set tx to shift bit 0 and go to DATA with bit index 0.
REQ-014 DATA SHALL send 8 bits LSB first, each held for exactly CLKS_PER_BIT cycles.
REQ-015 After bit index 7 completes, DATA SHALL set tx<=1 and go to STOP.
REQ-016 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE with busy<=0.
REQ-017 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from the first tx=0 cycle to the first IDLE cycle.
REQ-018 Back-to-back frames: minimum one IDLE cycle between frames; a frame-to-frame stop-bit gap of exactly 10*CLKS_PER_BIT+1 cycles between start-bit leading edges when the FIFO stays non-empty.
REQ-019 Deasserting enable mid-frame SHALL NOT abort the frame; it only blocks the next fetch.
REQ-020 empty or fifo_data changes during a frame SHALL NOT affect the frame in progress (shift register holds the latched copy).
REQ-021 With empty=1, or enable=0, in IDLE: no remove, tx=1, busy=0, indefinitely.
REQ-022 The counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL wrap to 0 at each bit boundary; no off-by-one at bit boundaries.
REQ-023 Exactly one remove pulse SHALL be issued per transmitted frame; no pop is issued without a frame.

Reset
REQ-024 While reset=1, regardless of the clock: state=IDLE, tx=1, busy=0, counter=0, bit index=0, shift register=0, remove=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately; the byte is lost.
REQ-026 After reset release, the first fetch SHALL occur at the first rising edge with enable=1 and empty=0.

Verification (CLKS_PER_BIT=4)
REQ-027 Reset, then enable=1 and empty=1 for 50 cycles -> remove never 1, tx=1, busy=0.
REQ-028 FIFO holds 0xA5, enable=1 -> one remove pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total), then busy=0.
REQ-029 FIFO holds 0x00 then 0xFF -> two frames, two remove pulses, start bits 41 cycles apart; data bits all 0 then all 1.
REQ-030 enable dropped at cycle 10 of a 0x3C frame -> frame completes correctly (40 cycles); no further remove while enable=0.
REQ-031 reset pulsed at cycle 15 of a frame -> tx=1, busy=0 in the same cycle; after release with FIFO non-empty, a fresh full frame starts.
REQ-032 fifo_data changed every cycle during a frame -> transmitted bits match the byte latched at the remove edge.
